// File: rtl/pkt_pkg.sv
// Shared types for the packet FIFO read path: packet width, packet type and
// the skid-buffer occupancy states.
package pkt_pkg;

    localparam int WIDTH_PACKET = 13;

    typedef logic [WIDTH_PACKET-1:0] pkt_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/pkt_skid_buf.sv
// Two-entry valid/ready skid buffer. The head entry drives the output and the
// skid entry holds the second packet. The state encoding is the occupancy.
//
//  state | meaning
//  EMPTY | no packet held, out_valid=0
//  ONE   | head valid, skid free
//  TWO   | head and skid both valid
module pkt_skid_buf
    import pkt_pkg::*;
#(
    parameter int WIDTH = pkt_pkg::WIDTH_PACKET
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [WIDTH-1:0] cap_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    buf_state_e       state_q;
    buf_state_e       state_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;
    logic             fire;
    logic             ld_head_cap;
    logic             ld_head_skid;
    logic             ld_skid;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;
    assign occ       = state_q;
    assign fire      = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture in TWO cannot happen: the issue logic never lets occupancy plus
    // in-flight reads exceed two.
    always_comb begin
        state_d      = state_q;
        ld_head_cap  = 1'b0;
        ld_head_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (capture) begin
                    state_d     = ONE;
                    ld_head_cap = 1'b1;
                end
            end
            ONE: begin
                if (capture && fire) begin
                    ld_head_cap = 1'b1;
                end else if (capture) begin
                    state_d = TWO;
                    ld_skid = 1'b1;
                end else if (fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (fire) begin
                    state_d      = ONE;
                    ld_head_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_head_cap) begin
                head_q <= cap_data;
            end else if (ld_head_skid) begin
                head_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= cap_data;
            end
        end
    end

endmodule

// File: rtl/fifo_pkt_reader.sv
// Read-side controller for the packet FIFO: issues pops, absorbs the FIFO's
// one-cycle read latency in a skid buffer. Optional macro FIFO_READER_PKT_CNT_EN.
module fifo_pkt_reader
    import pkt_pkg::*;
#(
    parameter int WIDTH_PACKET = pkt_pkg::WIDTH_PACKET,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    input  logic [WIDTH_PACKET-1:0] fifo_rd_data,
    output logic                    out_valid,
    output logic [WIDTH_PACKET-1:0] out_data,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [CNT_W-1:0]        pkt_count
);

    logic       inflight;
    logic [1:0] occ;
    logic       fire;
    logic [2:0] level_next;

    assign fire = out_valid & out_ready;

    // Packets held or owed after this cycle; never let that reach three.
    assign level_next = {1'b0, occ} + {2'b00, inflight} - {2'b00, fire};
    assign fifo_rd_en = enable & ~fifo_empty & (level_next < 3'd2);
    assign busy       = inflight | (occ != 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    pkt_skid_buf #(
        .WIDTH (WIDTH_PACKET)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .capture   (inflight),
        .cap_data  (fifo_rd_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .occ       (occ)
    );

`ifdef FIFO_READER_PKT_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count <= '0;
        end else if (fire) begin
            pkt_count <= pkt_count + 1'b1;
        end
    end
`else
    assign pkt_count = '0;
`endif

endmodule
